// File: rtl/l0_fifo.sv
// Row-parallel input staging FIFO for the MAC array's west edge: one FIFO per row,
// atomic writes across all rows, and reads popped all together or as a one-row-per-cycle skewed wave.
module l0_fifo #(
  parameter int row   = 8,
  parameter int bw    = 4,
  parameter int depth = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [row*bw-1:0] in,
  input  logic              wr,
  input  logic              rd,
  input  logic              rd_mode,
  output logic [row*bw-1:0] out,
  output logic [row-1:0]    o_valid,
  output logic              o_full,
  output logic              o_ready,
  output logic              o_empty
);

  localparam int aw = $clog2(depth);

  // Handshake: a write is accepted on an edge where wr=1 and o_ready=1; otherwise it is dropped.
  // On the read side, o_valid[r]=1 marks the cycle in which out slice r carries a freshly popped entry.

  logic [row-1:0] row_full;
  logic [row-1:0] row_empty;
  logic [row-1:0] pop;
  logic [row-1:0] rd_en;
  logic [row-1:0] skew;
  logic [row-1:0] skew_next;
  logic           flat;
  logic           wr_ok;

  assign o_full  = |row_full;
  assign o_ready = ~o_full;
  assign o_empty = &row_empty;
  assign wr_ok   = wr & ~o_full;

  // Mode-1 waves live in their own shift register so a later mode-0 read cannot
  // overwrite a wave already in flight; the two sources simply OR together.
  always_comb begin
    skew_next    = skew << 1;
    skew_next[0] = rd & rd_mode;
  end

  assign rd_en = skew | {row{flat}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skew <= '0;
      flat <= 1'b0;
    end else begin
      skew <= skew_next;
      flat <= rd & ~rd_mode;
    end
  end

  for (genvar g = 0; g < row; g++) begin : g_row
    logic [bw-1:0] mem [depth];
    logic [aw:0]   wr_ptr;
    logic [aw:0]   rd_ptr;
    logic [bw-1:0] out_q;
    logic          valid_q;

    assign row_empty[g] = (wr_ptr == rd_ptr);
    assign row_full[g]  = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
    assign pop[g]       = rd_en[g] & ~row_empty[g];

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[aw-1:0]] <= in[g*bw +: bw];
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        out_q   <= '0;
        valid_q <= 1'b0;
      end else begin
        if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop[g]) begin
          out_q  <= mem[rd_ptr[aw-1:0]];
          rd_ptr <= rd_ptr + 1'b1;
        end
        valid_q <= pop[g];
      end
    end

    assign out[g*bw +: bw] = out_q;
    assign o_valid[g]      = valid_q;
  end

endmodule

// File: tb/tb_l0_fifo.sv
// Directed bench for l0_fifo (row=8, bw=4, depth=64): a vector table for ordering,
// skew and empty-read cases plus hand sequences for reset, full/wrap and full+pop.
module tb_l0_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in;
  logic        wr, rd, rd_mode;
  logic [31:0] out;
  logic [7:0]  o_valid;
  logic        o_full, o_ready, o_empty;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  l0_fifo #(.row(8), .bw(4), .depth(64)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .rd_mode(rd_mode),
    .out(out), .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .o_empty(o_empty)
  );

  // clock / reset
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic        mode;
    logic [31:0] din;
    logic [31:0] exp_out;
    logic [7:0]  exp_valid;
    logic        exp_empty;
  } vec_t;

  vec_t vecs[23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs change 1 time unit after the edge, outputs sampled there too
  task automatic step(input logic w, input logic r, input logic m, input logic [31:0] d);
    wr = w; rd = r; rd_mode = m; in = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word_of(input int k);
    logic [31:0] w;
    for (int r = 0; r < 8; r++) w[r*4 +: 4] = 4'(k + r);
    return w;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    reset = 1'b1;
  endtask

  task automatic fill_64();
    for (int k = 0; k < 64; k++) begin
      step(1, 0, 0, word_of(k));
      exp_q.push_back(word_of(k));
    end
  endtask

  // arm a mode-0 read, then pop n entries back to back against the scoreboard
  task automatic drain(input int n, input string name);
    step(0, 1, 0, 32'h0);
    for (int i = 0; i < n; i++) begin
      step(0, (i < n - 1), 0, 32'h0);
      chk({name, "_valid"}, {24'h0, o_valid}, 32'hFF);
      if (exp_q.size() > 0) chk({name, "_data"}, out, exp_q.pop_front());
      else chk({name, "_underflow"}, 32'h1, 32'h0);
    end
  endtask

  initial begin
    wr = 0; rd = 0; rd_mode = 0; in = '0;
    do_reset();
    chk("rst_out", out, 32'h0);
    chk("rst_valid", {24'h0, o_valid}, 32'h0);
    chk("rst_empty", {31'h0, o_empty}, 32'h1);
    chk("rst_full", {31'h0, o_full}, 32'h0);
    chk("rst_ready", {31'h0, o_ready}, 32'h1);

    //         wr rd md din           exp_out       valid  empty
    vecs[0]  = '{1, 0, 0, 32'h76543210, 32'h00000000, 8'h00, 0};
    vecs[1]  = '{1, 0, 0, 32'hFEDCBA98, 32'h00000000, 8'h00, 0};
    vecs[2]  = '{0, 1, 0, 32'h0,        32'h00000000, 8'h00, 0};
    vecs[3]  = '{0, 1, 0, 32'h0,        32'h76543210, 8'hFF, 0};
    vecs[4]  = '{0, 0, 0, 32'h0,        32'hFEDCBA98, 8'hFF, 1};
    vecs[5]  = '{0, 0, 0, 32'h0,        32'hFEDCBA98, 8'h00, 1};
    vecs[6]  = '{0, 1, 0, 32'h0,        32'hFEDCBA98, 8'h00, 1};
    vecs[7]  = '{0, 0, 0, 32'h0,        32'hFEDCBA98, 8'h00, 1};
    vecs[8]  = '{0, 1, 0, 32'h0,        32'hFEDCBA98, 8'h00, 1};
    vecs[9]  = '{1, 0, 0, 32'h13579BDF, 32'hFEDCBA98, 8'h00, 0};
    vecs[10] = '{0, 1, 0, 32'h0,        32'hFEDCBA98, 8'h00, 0};
    vecs[11] = '{0, 0, 0, 32'h0,        32'h13579BDF, 8'hFF, 1};
    vecs[12] = '{1, 0, 0, 32'h76543210, 32'h13579BDF, 8'h00, 0};
    vecs[13] = '{0, 1, 1, 32'h0,        32'h13579BDF, 8'h00, 0};
    vecs[14] = '{0, 0, 0, 32'h0,        32'h13579BD0, 8'h01, 0};
    vecs[15] = '{0, 0, 0, 32'h0,        32'h13579B10, 8'h02, 0};
    vecs[16] = '{0, 0, 0, 32'h0,        32'h13579210, 8'h04, 0};
    vecs[17] = '{0, 0, 0, 32'h0,        32'h13573210, 8'h08, 0};
    vecs[18] = '{0, 0, 0, 32'h0,        32'h13543210, 8'h10, 0};
    vecs[19] = '{0, 0, 0, 32'h0,        32'h13543210, 8'h20, 0};
    vecs[20] = '{0, 0, 0, 32'h0,        32'h16543210, 8'h40, 0};
    vecs[21] = '{0, 0, 0, 32'h0,        32'h76543210, 8'h80, 1};
    vecs[22] = '{0, 0, 0, 32'h0,        32'h76543210, 8'h00, 1};

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].mode, vecs[i].din);
      chk($sformatf("vec%0d_out", i), out, vecs[i].exp_out);
      chk($sformatf("vec%0d_valid", i), {24'h0, o_valid}, {24'h0, vecs[i].exp_valid});
      chk($sformatf("vec%0d_empty", i), {31'h0, o_empty}, {31'h0, vecs[i].exp_empty});
      chk($sformatf("vec%0d_full", i), {31'h0, o_full}, 32'h0);
    end

    // reset in the middle of a mode-1 wave
    step(1, 0, 0, 32'h89ABCDEF);
    step(0, 1, 1, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    reset = 1'b0;
    step(0, 0, 0, 32'h0);
    chk("midrst_out", out, 32'h0);
    chk("midrst_valid", {24'h0, o_valid}, 32'h0);
    chk("midrst_empty", {31'h0, o_empty}, 32'h1);
    chk("midrst_full", {31'h0, o_full}, 32'h0);
    chk("midrst_ready", {31'h0, o_ready}, 32'h1);
    reset = 1'b1;
    step(0, 0, 0, 32'h0);
    chk("postrst_valid", {24'h0, o_valid}, 32'h0);
    step(1, 0, 0, 32'h24682468);
    chk("postrst_empty", {31'h0, o_empty}, 32'h0);
    exp_q.push_back(32'h24682468);
    drain(1, "postrst");
    chk("postrst_empty2", {31'h0, o_empty}, 32'h1);

    // full, dropped write, refill and wrapped drain
    do_reset();
    exp_q.delete();
    fill_64();
    chk("full_flag", {31'h0, o_full}, 32'h1);
    chk("full_ready", {31'h0, o_ready}, 32'h0);
    step(1, 0, 0, 32'h55555555);
    chk("drop_full", {31'h0, o_full}, 32'h1);
    drain(1, "pop1");
    chk("pop1_full", {31'h0, o_full}, 32'h0);
    step(1, 0, 0, 32'hAAAAAAAA);
    exp_q.push_back(32'hAAAAAAAA);
    chk("refill_full", {31'h0, o_full}, 32'h1);
    drain(64, "wrap");
    chk("wrap_last", out, 32'hAAAAAAAA);
    chk("wrap_empty", {31'h0, o_empty}, 32'h1);
    step(0, 0, 0, 32'h0);
    chk("wrap_idle_valid", {24'h0, o_valid}, 32'h0);

    // write plus pop on a full FIFO: pop wins, write dropped, 63 entries remain
    exp_q.delete();
    fill_64();
    step(0, 1, 0, 32'h0);
    step(1, 0, 0, 32'h99999999);
    chk("fullsim_valid", {24'h0, o_valid}, 32'hFF);
    chk("fullsim_data", out, exp_q.pop_front());
    chk("fullsim_full", {31'h0, o_full}, 32'h0);
    drain(63, "cnt63");
    chk("cnt63_empty", {31'h0, o_empty}, 32'h1);
    chk("cnt63_queue", exp_q.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/l0_fifo.md
# l0_fifo

Input staging buffer that sits directly upstream of the MAC array's west inputs. It holds one independent FIFO per array row. Each write pushes one bw-bit activation or weight into every row at once. Reads pop either all rows together or as a one-row-per-cycle skewed wave, so row r reaches the array r cycles after row 0, as the systolic flow requires. Outputs are registered and carry a per-row valid.

## Interface
- row, 8, number of array rows and independent row FIFOs
- bw, 4, data width per row entry
- depth, 64, entries per row FIFO; power of two, ≥ 2
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all state
- in  in  row*bw  write data; row r uses bits [(r+1)*bw-1 : r*bw]
- wr  in  1  write request: pushes all row slices of in
- rd  in  1  read request: starts a read wave
- rd_mode  in  1  0 = all rows pop together; 1 = skewed wave; sampled with rd
- out  out  row*bw  registered read data, same per-row packing as in
- o_valid  out  row  bit r = 1 for exactly one cycle after row r pops
- o_full  out  1  1 when any row FIFO holds depth entries
- o_ready  out  1  inverse of o_full
- o_empty  out  1  1 when every row FIFO holds 0 entries

## Operation
- Per-row storage: depth × bw memory, wr_ptr and rd_ptr each log2(depth)+1 bits.
- Per-row full and empty come from MSB-differing or equal pointers. Pointers wrap modulo 2·depth.
- Write is atomic across rows. If wr=1 and o_full=0, every row stores its slice at wr_ptr and increments wr_ptr.
- If wr=1 and o_full=1, the write is dropped. No pointer moves.
- Read-enable shift register rd_en[row-1:0]:
  - rd_mode=0: all bits load rd.
  - rd_mode=1: rd_en[0] loads rd and rd_en[r] loads rd_en[r-1], i.e. skewed by one cycle per row.
  - While rd=0 in mode 0, all bits load 0.
  - rd_mode may change between waves. A wave already in flight completes with its original skew.
- Row pop: when rd_en[r]=1 and row r is not empty, load out slice r from mem[rd_ptr], increment rd_ptr, and set o_valid[r]=1 for the next cycle.
- Empty-row read: a pop request on an empty row is ignored. rd_ptr is unchanged, o_valid[r]=0, and the out slice holds its value.
- Same-cycle wr and pop on an empty row: the pop is ignored; there is no bypass. The written data becomes poppable from the next cycle.
- Same-cycle wr and pop on a full row: the write is dropped because o_full is evaluated from the pre-edge state. The pop proceeds.
- Out slices hold their last popped value while no pop occurs.
- Reset, at any time including mid-wave:
  - all pointers, rd_en, out and o_valid go to 0;
  - o_full=0, o_ready=1, o_empty=1;
  - memory contents are not cleared;
  - any in-flight wave is abandoned.

## Timing
- Write at edge N is visible to a pop at edge N+1 or later.
- Read latency:
  - rd=1 sampled at edge N arms rd_en. Row r pops at edge N+1 in mode 0, and at edge N+1+r in mode 1.
  - out and o_valid update on that same pop edge.
- A full mode-1 wave spans row cycles. Back-to-back rd pulses in mode 1 produce overlapping waves, one row pop per row per cycle.
- o_full, o_ready and o_empty are registered-pointer functions. They update on the edge after the causing write or pop.
- No combinational path from in, wr or rd to any output.

## Test plan
- Reset and flags: assert reset=0 mid-wave → next cycle out=0, o_valid=0, o_empty=1, o_full=0, o_ready=1. Release reset and write one word → o_empty=0.
- Mode 0 ordering: write 0x76543210 then 0xFEDCBA98 (row=8, bw=4), then rd=1 for 2 cycles, rd_mode=0 → out=0x76543210 with o_valid=0xFF, then 0xFEDCBA98, then o_valid=0x00.
- Mode 1 skew: after the same writes, a single rd pulse with rd_mode=1 → o_valid steps 0x01, 0x02, … 0x80 on consecutive cycles. Row r's slice equals nibble r of 0x76543210.
- Full and wrap:
  - write 64 words → o_full=1 and o_ready=0;
  - a 65th write is dropped;
  - pop 1 (mode 0) and write 0xA → o_full=1 again;
  - drain 64 → values in order, the last one is 0xA per row, pointers have wrapped, o_empty=1.
- Empty-read boundary: rd=1 in mode 0 on an empty FIFO → o_valid stays 0x00 and out holds. wr with rd in the same cycle on an empty FIFO → no pop; the data pops on the next rd.
- Full simultaneous: on a full FIFO, wr plus rd in mode 0 in the same cycle → pop succeeds, write dropped, count = 63.
